// File: rtl/sha_pkg.sv
// Shared definitions for the SHA block pipeline: message geometry and the
// LOAD/VALID handshake state encoding used by input_buffer, the core and output_buffer.
package sha_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 16;
  localparam int ADDR_W    = 5;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  // Bit offset of the least significant bit of word address a (1-based).
  function automatic int word_lsb(input int a, input int w, input int n);
    return w * (n - a);
  endfunction

endpackage

// File: rtl/input_buffer.sv
// Host-facing message block buffer: collects NUM_WORDS words by address,
// then offers the assembled block to the hash core with a valid/ready handshake.
module input_buffer #(
  parameter int WORD_W    = sha_pkg::WORD_W,
  parameter int NUM_WORDS = sha_pkg::NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [4:0]                  addr,
  input  logic [WORD_W-1:0]           in_var,
  input  logic                        start,
  input  logic                        clr_err,
  input  logic                        blk_ready,
  output logic                        blk_valid,
  output logic [WORD_W*NUM_WORDS-1:0] out_block,
  output logic [NUM_WORDS-1:0]        wr_mask,
  output logic                        busy,
  output logic                        err
);
  import sha_pkg::ST_LOAD;
  import sha_pkg::ST_VALID;
  import sha_pkg::word_lsb;

  // Handshake: the block transfers on the cycle where blk_valid and blk_ready
  // are both high; blk_valid never drops and out_block never changes before that.

  logic [0:0]           state;
  logic [0:0]           state_next;
  logic [WORD_W-1:0]    words [NUM_WORDS];
  logic [NUM_WORDS-1:0] wr_onehot;
  logic [NUM_WORDS-1:0] mask_next;
  logic                 in_load;
  logic                 in_valid;
  logic                 addr_ok;
  logic                 wr_hit;
  logic                 mask_full;
  logic                 take;
  logic                 xfer;
  logic                 err_set;

  assign in_load  = (state == ST_LOAD);
  assign in_valid = (state == ST_VALID);
  assign addr_ok  = (addr != 5'd0) && (int'(addr) <= NUM_WORDS);
  assign wr_hit   = in_load && en && addr_ok;

  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (wr_hit && (int'(addr) == i + 1)) wr_onehot[i] = 1'b1;
    end
  end

  // start sees the mask including a write landing in the same cycle.
  assign mask_next = wr_mask | wr_onehot;
  assign mask_full = &mask_next;
  assign take      = in_load && start && mask_full;
  assign xfer      = in_valid && blk_ready;

  assign err_set = (in_load && en && !addr_ok)
                || (in_load && start && !mask_full)
                || (in_valid && en);

  always_comb begin
    state_next = state;
    if (take)      state_next = ST_VALID;
    else if (xfer) state_next = ST_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      wr_mask <= '0;
      err     <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
    end else begin
      state <= state_next;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wr_onehot[i]) words[i] <= in_var;
      end
      if (xfer) wr_mask <= '0;
      else      wr_mask <= mask_next;
      // A new error wins over a same-cycle clear.
      if (err_set)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  always_comb begin
    out_block = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      out_block[word_lsb(i + 1, WORD_W, NUM_WORDS) +: WORD_W] = words[i];
    end
  end

  assign blk_valid = in_valid;
  assign busy      = in_valid;

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 Parameter WORD_W, default 32: width of one message word.
REQ-002 Parameter NUM_WORDS, default 16: words per 512-bit message block.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  host write strobe for one word.
REQ-006 addr  input  5  word address, valid range 1..16; 0 and 17..31 are out of range.
REQ-007 in_var  input  32  host data word.
REQ-008 start  input  1  host request to commit the current block to the hash core.
REQ-009 clr_err  input  1  clears the sticky error flag.
REQ-010 blk_ready  input  1  hash core accepts the block.
REQ-011 blk_valid  output  1  block presented to the hash core.
REQ-012 out_block  output  512  message block; word addr 1 at [511:480], word addr 16 at [31:0].
REQ-013 wr_mask  output  16  bit i-1 set once word i has been written in the current block.
REQ-014 busy  output  1  high while the block waits for the core.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The FSM SHALL have two states: LOAD (host fills words) and VALID (block offered to the core).
REQ-017 In LOAD, en=1 with addr 1..16 SHALL write in_var into word addr at the next edge and set wr_mask bit addr-1; the new value is visible on out_block and wr_mask one cycle after the strobe.
REQ-018 In LOAD, en=1 with an out-of-range addr SHALL change no word or mask bit and SHALL set err.
REQ-019 Rewriting an already-written word in LOAD SHALL overwrite it without error.
REQ-020 In LOAD, start=1 SHALL be evaluated against the mask including any same-cycle write; if all 16 bits are set, the FSM SHALL go to VALID at the next edge.
REQ-021 In LOAD, start=1 with an incomplete mask SHALL be ignored and SHALL set err.
REQ-022 blk_valid and busy SHALL be high exactly while in VALID, i.e. from the cycle after an accepted start.
REQ-023 In VALID, out_block SHALL be held stable until the transfer cycle (blk_valid=1 and blk_ready=1).
REQ-024 After the transfer cycle, the FSM SHALL return to LOAD with wr_mask=0; word registers keep their values.
REQ-025 blk_ready while in LOAD SHALL be ignored.
REQ-026 In VALID, en=1 SHALL be ignored for data and SHALL set err; start=1 SHALL be ignored without error.
REQ-027 err SHALL stay high until clr_err=1 or rst=1.
REQ-028 If clr_err and a new error occur in the same cycle, err SHALL be 1.

Reset
REQ-029 rst=1 SHALL force, at the next edge: state LOAD, all word registers 0, wr_mask 0, blk_valid 0, busy 0, err 0.
REQ-030 rst SHALL take priority over all other inputs, including mid-fill and while in VALID; a pending block is discarded.

Structure
REQ-031 WORD_W, NUM_WORDS and the LOAD/VALID state encoding SHALL live in a shared package, sha_pkg, also used by the hash core and output_buffer.
REQ-032 The block SHALL be implemented as a single module with the address decode and mask logic inline; no sub-module is required.

Verification
REQ-033 Load "abc": word 1=0x61626380, words 2..15=0, word 16=0x00000018, then start -> blk_valid=1 the next cycle, out_block[511:480]=0x61626380, out_block[31:0]=0x00000018.
REQ-034 Write words 1..15 only, then start -> blk_valid stays 0, err=1; write word 16, then start -> blk_valid=1.
REQ-035 Hold blk_ready=0 for 5 cycles in VALID while en=1 with addr 3 and 0xDEADBEEF -> out_block unchanged, err=1; blk_ready=1 -> next cycle blk_valid=0, wr_mask=0x0000.
REQ-036 Write addr 0 and addr 17 -> wr_mask unchanged, err=1; clr_err=1 -> err=0 the next cycle.
REQ-037 Write word 16 and assert start in the same cycle (words 1..15 already written) -> blk_valid=1 the next cycle.
REQ-038 Assert rst while in VALID -> next cycle blk_valid=0, wr_mask=0, out_block=0, err=0.
